// File: rtl/or1200_operandmuxes_multi.sv
// ---------------------------------------------------------------------------
// or1200_operandmuxes_multi
// Operand select and capture for the ID->EX boundary, generalised to NPORTS
// operand ports and NFWD forwarding sources.
//
// Each port has a combinational select among register-file data, the shared
// immediate and the forwarded results (muxed). It also has a registered
// capture stage (operand) with ID/EX freeze hold and EX flush.
//
// Optional feature: define OR1200_OPMUX_FWD_STATS_EN to enable saturating
// per-port forward-hit counters on fwd_cnt. When it is undefined, fwd_cnt is
// tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_freeze, ex_freeze stage stall qualifiers
//   ex_flush             discard captured operands (wins over freezes)
//   rf_data  [NPORTS*WIDTH]  register-file data, port p at [p*WIDTH +: WIDTH]
//   fwd_data [NFWD*WIDTH]    forwarded results, source k at [k*WIDTH +: WIDTH]
//   imm      [WIDTH]         shared sign-extended immediate
//   sel      [NPORTS*SEL_W]  per-port select
//   muxed    [NPORTS*WIDTH]  combinational selected operands
//   operand  [NPORTS*WIDTH]  registered operands to EX
//   saved    [NPORTS]        per-port HELD flag
//   fwd_cnt  [NPORTS*CNT_W]  per-port forward-hit counters
// ---------------------------------------------------------------------------
module or1200_operandmuxes_multi #(
  parameter int unsigned        WIDTH    = 32,
  parameter int unsigned        NPORTS   = 3,
  parameter int unsigned        NFWD     = 3,
  parameter logic [NPORTS-1:0]  IMM_MASK = NPORTS'(3'b010),
  parameter int unsigned        CNT_W    = 16,
  localparam int unsigned       SEL_W    = $clog2(NFWD + 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_freeze,
  input  logic                      ex_freeze,
  input  logic                      ex_flush,
  input  logic [NPORTS*WIDTH-1:0]   rf_data,
  input  logic [NFWD*WIDTH-1:0]     fwd_data,
  input  logic [WIDTH-1:0]          imm,
  input  logic [NPORTS*SEL_W-1:0]   sel,
  output logic [NPORTS*WIDTH-1:0]   muxed,
  output logic [NPORTS*WIDTH-1:0]   operand,
  output logic [NPORTS-1:0]         saved,
  output logic [NPORTS*CNT_W-1:0]   fwd_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [SEL_W-1:0] w_sel;
    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] w_operand_nxt;
    logic [WIDTH-1:0] r_operand;
    state_e           w_state_nxt;
    state_e           r_state;

    assign w_sel = sel[p*SEL_W +: SEL_W];

    // Operand select; unused encodings fall back to register-file data.
    always_comb begin
      w_mux = rf_data[p*WIDTH +: WIDTH];
      if (w_sel == SEL_W'(1) && IMM_MASK[p]) begin
        w_mux = imm;
      end
      for (int k = 0; k < int'(NFWD); k++) begin
        if (w_sel == SEL_W'(k + 2)) begin
          w_mux = fwd_data[k*WIDTH +: WIDTH];
        end
      end
    end

    // Capture FSM: capture once on entering an ID stall, then hold until the
    // stall releases. The release edge only leaves HELD and does not capture.
    always_comb begin
      w_state_nxt   = r_state;
      w_operand_nxt = r_operand;
      if (ex_flush) begin
        w_state_nxt   = ST_IDLE;
        w_operand_nxt = '0;
      end else if (!ex_freeze) begin
        unique case (r_state)
          ST_IDLE: begin
            w_operand_nxt = w_mux;
            w_state_nxt   = id_freeze ? ST_HELD : ST_IDLE;
          end
          ST_HELD: begin
            if (!id_freeze) begin
              w_state_nxt = ST_IDLE;
            end
          end
        endcase
      end
    end

    // State and operand registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_operand <= '0;
      end else begin
        r_state   <= w_state_nxt;
        r_operand <= w_operand_nxt;
      end
    end

    assign muxed[p*WIDTH +: WIDTH]   = w_mux;
    assign operand[p*WIDTH +: WIDTH] = r_operand;
    assign saved[p]                  = (r_state == ST_HELD);

`ifdef OR1200_OPMUX_FWD_STATS_EN
    logic             w_capture;
    logic             w_fwd_hit;
    logic [CNT_W-1:0] r_cnt;

    assign w_capture = !ex_flush && !ex_freeze && (r_state == ST_IDLE);
    assign w_fwd_hit = (w_sel >= SEL_W'(2)) && (w_sel <= SEL_W'(NFWD + 1));

    // Saturating forward-hit counter; only reset clears it.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_capture && w_fwd_hit && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign fwd_cnt[p*CNT_W +: CNT_W] = r_cnt;
`else
    assign fwd_cnt[p*CNT_W +: CNT_W] = '0;
`endif
  end

endmodule
